// File: rtl/hud_pkg.sv
// Shared constants, FSM state type and BCD helpers for the HUD score writer.
package hud_pkg;

    localparam int HUD_SLOTS        = 14;
    localparam int DIGITS_PER_VALUE = 7;
    localparam int BCD_W            = 28;
    localparam int MAX_DEC          = 9_999_999;

    // Iteration counter width; must hold the binary input width.
    localparam int ITER_W = 5;

    // First slot of each readout in the overlay.
    localparam logic [3:0] SLOT_BASE_A = 4'd0;
    localparam logic [3:0] SLOT_BASE_B = 4'd7;

    typedef enum logic [2:0] {
        IDLE,
        CONV_A,
        EMIT_A,
        CONV_B,
        EMIT_B,
        FINISH
    } state_t;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // Digit k of a packed 7-digit BCD word, k = 0 being the most significant.
    function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] bcd,
                                             input logic [2:0]       k);
        logic [BCD_W-1:0] shifted;
        shifted = bcd >> (4 * (DIGITS_PER_VALUE - 1 - int'(k)));
        return shifted[3:0];
    endfunction

    // True when digits 0..k (most significant first) are all zero.
    function automatic logic digits_zero_through(input logic [BCD_W-1:0] bcd,
                                                 input logic [2:0]       k);
        logic [BCD_W-1:0] shifted;
        shifted = bcd >> (4 * (DIGITS_PER_VALUE - 1 - int'(k)));
        return (shifted == '0);
    endfunction

endpackage

// File: rtl/hud_score_writer_bin2bcd_serial.sv
// Serial double-dabble: one iteration per step, BIN_W steps per conversion.
// The caller loads a value, then steps until last is seen alongside a step.
module bin2bcd_serial
    import hud_pkg::*;
#(
    parameter int BIN_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [BIN_W-1:0] bin_in,
    output logic [BCD_W-1:0] bcd,
    output logic             last
);

    logic [BIN_W-1:0]  bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_adj;
    logic [ITER_W-1:0] iter_q;

    // Add 3 to every nibble that is 5 or more, ready for the next shift.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        bcd_adj = '0;
        for (int i = 0; i < DIGITS_PER_VALUE; i++) begin
            bcd_adj[4*i +: 4] = add3_if_ge5(bcd_q[4*i +: 4]);
        end
    end

    // Load clears the BCD word; each step shifts the corrected BCD word and the binary value left.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!reset_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
        end else if (load) begin
            bin_q  <= bin_in;
            bcd_q  <= '0;
            iter_q <= '0;
        end else if (step) begin
            bcd_q  <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_q  <= {bin_q[BIN_W-2:0], 1'b0};
            iter_q <= iter_q + ITER_W'(1);
        end
    end

    assign bcd  = bcd_q;
    // The step taking place at this edge is the final one of the conversion.
    assign last = step && (iter_q == ITER_W'(BIN_W - 1));

endmodule

// File: rtl/hud_score_writer.sv
// Captures two counters, converts each to 7 BCD digits and writes the 14
// digit slots of the HUD overlay one per cycle, with optional blanking of
// leading zeros. All outputs are registered.
module hud_score_writer
    import hud_pkg::*;
#(
    parameter int         BIN_W         = 24,
    parameter logic [3:0] BLANK_CODE    = 4'd10,
    parameter bit         BLANK_LEADING = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] value_a,
    input  logic [BIN_W-1:0] value_b,
    output logic             busy,
    output logic             done,
    output logic             write,
    output logic [3:0]       num,
    output logic [3:0]       blob
);

    localparam logic [BIN_W-1:0] MAX_VAL   = BIN_W'(MAX_DEC);
    localparam logic [2:0]       LAST_SLOT = 3'(DIGITS_PER_VALUE - 1);

    // Values beyond seven decimal digits display as all nines.
    function automatic logic [BIN_W-1:0] clamp(input logic [BIN_W-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    state_t           state_q;
    state_t           state_d;
    logic [BIN_W-1:0] value_b_q;
    logic [2:0]       emit_k_q;
    logic             last_digit;
    logic             accept;

    logic             conv_load;
    logic             conv_step;
    logic [BIN_W-1:0] conv_bin;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_last;

    logic             busy_d;
    logic             done_d;
    logic             write_d;
    logic [3:0]       num_d;
    logic [3:0]       blob_d;

    // busy is low exactly in IDLE, which includes the cycle done is high.
    assign accept     = (state_q == IDLE) && start;
    assign last_digit = (emit_k_q == LAST_SLOT);

    bin2bcd_serial #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (conv_load),
        .step    (conv_step),
        .bin_in  (conv_bin),
        .bcd     (conv_bcd),
        .last    (conv_last)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: convert A, emit A, convert B, emit B, then finish.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)     state_d = CONV_A;
            CONV_A:  if (conv_last)  state_d = EMIT_A;
            EMIT_A:  if (last_digit) state_d = CONV_B;
            CONV_B:  if (conv_last)  state_d = EMIT_B;
            EMIT_B:  if (last_digit) state_d = FINISH;
            FINISH:                  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Converter control: A is loaded on capture, B as the last A digit goes out.
    always_comb begin
        conv_load = accept || ((state_q == EMIT_A) && last_digit);
        conv_step = (state_q == CONV_A) || (state_q == CONV_B);
        conv_bin  = (state_q == IDLE) ? clamp(value_a) : value_b_q;
    end

    // Hold the clamped right readout until its conversion starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_b_q <= '0;
        end else if (accept) begin
            value_b_q <= clamp(value_b);
        end
    end

    // Digit index within the readout currently being emitted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            emit_k_q <= '0;
        end else if ((state_q == EMIT_A) || (state_q == EMIT_B)) begin
            emit_k_q <= last_digit ? 3'd0 : emit_k_q + 3'd1;
        end else begin
            emit_k_q <= '0;
        end
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        write_d = (state_q == EMIT_A) || (state_q == EMIT_B);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == FINISH);
        num_d   = num;
        blob_d  = blob;
        if (write_d) begin
            blob_d = ((state_q == EMIT_B) ? SLOT_BASE_B : SLOT_BASE_A) + {1'b0, emit_k_q};
            num_d  = bcd_digit(conv_bcd, emit_k_q);
            // The least significant digit always shows, so zero reads as "0".
            if (BLANK_LEADING && !last_digit && digits_zero_through(conv_bcd, emit_k_q)) begin
                num_d = BLANK_CODE;
            end
        end
    end

    // Output registers; num and blob keep the last written slot between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            write <= 1'b0;
            num   <= '0;
            blob  <= '0;
        end else begin
            busy  <= busy_d;
            done  <= done_d;
            write <= write_d;
            num   <= num_d;
            blob  <= blob_d;
        end
    end

endmodule

// File: tb/tb_hud_score_writer.sv
// Randomised and directed bench for hud_score_writer. Two instances run side
// by side, with and without leading-zero blanking, against a timeline model.
`timescale 1ns/1ps
module tb_hud_score_writer;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic [23:0] value_a = '0;
    logic [23:0] value_b = '0;

    logic        busy1, done1, write1;
    logic [3:0]  num1, blob1;
    logic        busy0, done0, write0;
    logic [3:0]  num0, blob0;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt = 0;

    hud_score_writer #(.BIN_W(24), .BLANK_CODE(4'd10), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .value_a(value_a), .value_b(value_b),
        .busy(busy1), .done(done1), .write(write1), .num(num1), .blob(blob1)
    );

    hud_score_writer #(.BIN_W(24), .BLANK_CODE(4'd10), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .start(start), .value_a(value_a), .value_b(value_b),
        .busy(busy0), .done(done0), .write(write0), .num(num0), .blob(blob0)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected code shown in digit k (0 = most significant) of a readout.
    function automatic int exp_code(input int unsigned v, input bit blank, input int k);
        int unsigned c;
        int unsigned p;
        int d;
        bit seen;
        c = (v > 9999999) ? 9999999 : v;
        seen = 1'b0;
        d = 0;
        for (int j = 0; j <= k; j++) begin
            p = 1;
            for (int e = 0; e < 6 - j; e++) p = p * 10;
            d = int'((c / p) % 10);
            if (d != 0) seen = 1'b1;
        end
        if (blank && !seen && k < 6) return 10;
        return d;
    endfunction

    // Model: m_t counts edges since the accepting edge (-1 when idle).
    int m_t = -1;
    int m_dig1 [14];
    int m_dig0 [14];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_t <= -1;
        end else if (m_t < 0 || m_t == 63) begin
            if (start) begin
                m_t <= 0;
                for (int k = 0; k < 7; k++) begin
                    m_dig1[k]     <= exp_code(value_a, 1'b1, k);
                    m_dig1[7 + k] <= exp_code(value_b, 1'b1, k);
                    m_dig0[k]     <= exp_code(value_a, 1'b0, k);
                    m_dig0[7 + k] <= exp_code(value_b, 1'b0, k);
                end
            end else begin
                m_t <= -1;
            end
        end else begin
            m_t <= m_t + 1;
        end
    end

    function automatic int ex_busy(input int t);  return (t >= 0 && t <= 62) ? 1 : 0; endfunction
    function automatic int ex_done(input int t);  return (t == 63) ? 1 : 0; endfunction
    function automatic int ex_write(input int t);
        return ((t >= 25 && t <= 31) || (t >= 56 && t <= 62)) ? 1 : 0;
    endfunction
    function automatic int ex_slot(input int t);  return (t <= 31) ? t - 25 : t - 49; endfunction

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        check("busy",    int'(busy1),  ex_busy(m_t));
        check("done",    int'(done1),  ex_done(m_t));
        check("write",   int'(write1), ex_write(m_t));
        check("busy_nb", int'(busy0),  ex_busy(m_t));
        check("done_nb", int'(done0),  ex_done(m_t));
        check("write_nb", int'(write0), ex_write(m_t));
        if (ex_write(m_t) == 1) begin
            check("blob",    int'(blob1), ex_slot(m_t));
            check("num",     int'(num1),  m_dig1[ex_slot(m_t)]);
            check("blob_nb", int'(blob0), ex_slot(m_t));
            check("num_nb",  int'(num0),  m_dig0[ex_slot(m_t)]);
        end
    end

    // Observed writes and done pulses, for directed literal checks.
    int obs1_num[$], obs1_blob[$], obs1_edge[$];
    int obs0_num[$];
    int done_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (write1) begin
            obs1_num.push_back(int'(num1));
            obs1_blob.push_back(int'(blob1));
            obs1_edge.push_back(edge_cnt);
        end
        if (write0) obs0_num.push_back(int'(num0));
        if (done1) done_cnt++;
    end

    task automatic clear_obs();
        obs1_num.delete();
        obs1_blob.delete();
        obs1_edge.delete();
        obs0_num.delete();
        done_cnt = 0;
    endtask

    // Raise start for one cycle; n is the edge that samples it.
    task automatic pulse_start(input int unsigned a, input int unsigned b, output int n);
        @(negedge clk);
        clear_obs();
        value_a = 24'(a);
        value_b = 24'(b);
        start   = 1'b1;
        n       = edge_cnt + 1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done1 === 1'b1) return;
        end
        check({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic check_timing(input string tag, input int n);
        check({tag, "_t_done"}, edge_cnt - n, 63);
        check({tag, "_nwrites"}, obs1_num.size(), 14);
        if (obs1_edge.size() >= 14) begin
            check({tag, "_t_a_first"}, obs1_edge[0] - n, 25);
            check({tag, "_t_a_last"},  obs1_edge[6] - n, 31);
            check({tag, "_t_b_first"}, obs1_edge[7] - n, 56);
            check({tag, "_t_b_last"},  obs1_edge[13] - n, 62);
        end
    endtask

    task automatic check_digits(input string tag, input int e1 [14], input int e0 [14]);
        check({tag, "_count"},    obs1_num.size(), 14);
        check({tag, "_count_nb"}, obs0_num.size(), 14);
        for (int i = 0; i < 14; i++) begin
            if (i < obs1_num.size()) begin
                check($sformatf("%s_num%0d", tag, i),  obs1_num[i],  e1[i]);
                check($sformatf("%s_blob%0d", tag, i), obs1_blob[i], i);
            end
            if (i < obs0_num.size()) check($sformatf("%s_nb_num%0d", tag, i), obs0_num[i], e0[i]);
        end
    endtask

    function automatic int unsigned rand_val();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 999);
            1:       return $urandom_range(0, 9999999);
            2:       return $urandom_range(9999990, 10000010);
            default: return $urandom & 32'hFF_FFFF;
        endcase
    endfunction

    initial begin
        int n;
        int e1 [14];
        int e0 [14];

        // Model pins.
        check("pin_42_k4", exp_code(42, 1'b1, 4), 10);
        check("pin_42_k5", exp_code(42, 1'b1, 5), 4);
        check("pin_0_k6",  exp_code(0, 1'b1, 6), 0);
        check("pin_sat",   exp_code(10000000, 1'b0, 0), 9);

        // Asynchronous reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy",  int'(busy1),  0);
        check("rst_done",  int'(done1),  0);
        check("rst_write", int'(write1), 0);
        check("rst_num",   int'(num1),   0);
        check("rst_blob",  int'(blob1),  0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full digits.
        pulse_start(1234567, 7654321, n);
        wait_done("full");
        check_timing("full", n);
        e1 = '{1,2,3,4,5,6,7,7,6,5,4,3,2,1};
        check_digits("full", e1, e1);

        // Leading-zero blanking.
        pulse_start(42, 0, n);
        wait_done("blank");
        e1 = '{10,10,10,10,10,4,2,10,10,10,10,10,10,0};
        e0 = '{0,0,0,0,0,4,2,0,0,0,0,0,0,0};
        check_digits("blank", e1, e0);

        // Saturation.
        pulse_start(16777215, 10000000, n);
        wait_done("sat");
        e1 = '{9,9,9,9,9,9,9,9,9,9,9,9,9,9};
        check_digits("sat", e1, e1);

        // Handshake: starts while busy are ignored; start in the done cycle is accepted.
        pulse_start(1234567, 7654321, n);
        while (edge_cnt < n + 4) @(negedge clk);
        value_a = 24'd111; value_b = 24'd222; start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (edge_cnt < n + 39) @(negedge clk);
        value_a = 24'd333; value_b = 24'd444; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("hs");
        check_timing("hs", n);
        e1 = '{1,2,3,4,5,6,7,7,6,5,4,3,2,1};
        check_digits("hs", e1, e1);
        value_a = 24'd5; value_b = 24'd6; start = 1'b1;
        n = edge_cnt + 1;
        @(negedge clk); start = 1'b0;
        check("hs_one_done", done_cnt, 1);
        check("hs_busy_after_done_start", int'(busy1), 1);
        clear_obs();
        wait_done("hs2");
        check_timing("hs2", n);

        // Reset in the middle of a run.
        pulse_start(7654321, 1234567, n);
        while (edge_cnt < n + 39) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy",  int'(busy1),  0);
        check("mid_rst_done",  int'(done1),  0);
        check("mid_rst_write", int'(write1), 0);
        clear_obs();
        while (edge_cnt < n + 44) @(negedge clk);
        reset_n = 1'b1;
        while (edge_cnt < n + 48) @(negedge clk);
        check("mid_rst_no_writes", obs1_num.size(), 0);
        check("mid_rst_no_done", done_cnt, 0);
        begin
            int n0;
            n0 = n;
            pulse_start(9876543, 31, n);
            check("mid_rst_restart_edge", n - n0, 50);
        end
        wait_done("restart");
        check_timing("restart", n);

        // Randomised runs, with occasional ignored starts mid-run.
        for (int r = 0; r < 14; r++) begin
            pulse_start(rand_val(), rand_val(), n);
            if ($urandom_range(0, 1) == 1) begin
                int off;
                off = $urandom_range(1, 60);
                while (edge_cnt < n + off) @(negedge clk);
                value_a = 24'($urandom); value_b = 24'($urandom); start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
            wait_done($sformatf("rand%0d", r));
            check($sformatf("rand%0d_nwrites", r), obs1_num.size(), 14);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
